dmux_stream: RTL and testbench
==============================

# dmux_stream

Parametrised 1-to-CHANNELS stream demultiplexer with valid/ready flow control and a one-entry registered output slot per channel. It replaces the single-bit combinational 1:2 demux with a registered, back-pressured datapath. Each word is routed to one channel selected by `in_sel`, or to all channels when `in_bcast` is set. Out-of-range selects are discarded and counted. The block sits between a single producer and CHANNELS independent consumers.

## Interface
- `WIDTH`, 8, data word width in bits (≥1)
- `CHANNELS`, 4, number of output channels (2..16; need not be a power of two)
- `SEL_W`, derived, `$clog2(CHANNELS)`; not overridden by the instantiator
- `CNT_W`, 8, width of the drop counter
- `clk`  input  1  single clock; all state updates on the rising edge
- `rst`  input  1  synchronous, active-high reset
- `in_data`  input  WIDTH  input word
- `in_sel`  input  SEL_W  destination channel index
- `in_bcast`  input  1  1 = deliver the word to every channel; `in_sel` is ignored
- `in_valid`  input  1  producer offers a word
- `in_ready`  output  1  block accepts the word this cycle (combinational)
- `out_data`  output  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]; registered
- `out_valid`  output  CHANNELS  per-channel slot-full flag; registered
- `out_ready`  input  CHANNELS  per-channel consumer ready
- `drop_cnt`  output  CNT_W  saturating count of words discarded for an out-of-range select

## Operation
- Per-channel slot state is EMPTY (`out_valid[k]`=0) or FULL (`out_valid[k]`=1).
- Channel k can load when `free[k]` = !out_valid[k] | out_ready[k].
- `in_ready` is computed as follows:
  - Broadcast: AND of all `free[k]`.
  - Unicast with `in_sel` < CHANNELS: `free[in_sel]`.
  - Unicast with `in_sel` ≥ CHANNELS: 1.
- An accept occurs when `in_valid` & `in_ready`.
- On a unicast accept with an in-range select, only channel `in_sel` loads `in_data` and sets `out_valid`.
- On a broadcast accept, every channel loads `in_data` and sets `out_valid` in the same cycle. Broadcast is all-or-nothing: no partial delivery.
- On an accept with an out-of-range select:
  - No channel changes.
  - `drop_cnt` increments by 1 and holds at 2^CNT_W−1.
- Drain: when `out_valid[k]` & `out_ready[k]` and no load is targeted at k, `out_valid[k]` clears. `out_data[k]` holds its last value.
- Simultaneous drain and load on the same channel: the new word replaces the old one and `out_valid[k]` stays 1. This gives full throughput.
- Channels are independent. A stalled channel blocks only unicasts to itself and broadcasts.
- Producer rule: `in_data`, `in_sel` and `in_bcast` stay stable while `in_valid` is high and `in_ready` is low. The block does not check this.
- There is no combinational path from `in_*` to `out_*`. The only combinational paths are `in_sel`/`in_bcast`/`out_ready` → `in_ready`.

## Timing
- Reset values, applied on the first rising edge with `rst`=1:
  - `out_valid` = 0, `out_data` = 0, `drop_cnt` = 0.
  - `in_ready` then follows the reset state: 1 for every select.
- A reset asserted mid-operation discards all held words on that edge. An input accept in the same cycle as `rst` is ignored.
- Latency: accept at edge N makes `out_valid[k]` = 1 with the new data visible after edge N.
- Throughput: one word per cycle into any channel whose `out_ready` is held high. Broadcasts also run one per cycle when all `out_ready` are high.
- `drop_cnt` updates on the accept edge. Once saturated it does not wrap.
- `out_data`/`out_valid` of a FULL channel stay stable until that channel's handshake completes.

## Test plan
- **Reset and idle.** Drive `rst`=1 for 2 cycles with `in_valid`=1 and `in_sel`=1 → after release, `out_valid`=4'b0000, `out_data`=0, `drop_cnt`=0, `in_ready`=1.
- **Unicast routing.** With all `out_ready`=1, send 8'hA0..8'hA3 with `in_sel`=0..3 on consecutive cycles → each channel k shows A0+k for exactly one cycle, one cycle after its accept, with no stall.
- **Back-pressure.**
  - Set `out_ready[2]`=0 and send two words to ch2 → the first is held, `in_ready`=0 for the second.
  - Meanwhile a word to ch1 is accepted.
  - Raise `out_ready[2]` → the second word is accepted on the same cycle the first drains; `out_valid[2]` stays 1.
- **Broadcast.**
  - Fill ch3 with `out_ready[3]`=0, then offer `in_bcast`=1 with 8'h5A → `in_ready`=0 and no channel changes.
  - Release ch3 → all four channels show 5A in the same cycle.
- **Out-of-range.** Use CHANNELS=3 and `in_sel`=3 for 300 accepts with CNT_W=8 → `in_ready` is always 1, no `out_valid` is raised, and `drop_cnt` ends at 255.
- **Reset mid-operation.** With ch0 and ch1 FULL and stalled, pulse `rst` for 1 cycle together with a valid unicast → `out_valid`=0 and `drop_cnt`=0 next cycle, and the concurrent word is not delivered.

Source files
------------

// File: rtl/dmux_stream.sv
// dmux_stream: 1-to-CHANNELS valid/ready stream demux with registered per-channel slots
module dmux_stream #(
    parameter int WIDTH = 8,
    parameter int CHANNELS = 4,
    parameter int CNT_W = 8,
    localparam int SEL_W = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WIDTH-1:0]          in_data,
    input  logic [SEL_W-1:0]          in_sel,
    input  logic                      in_bcast,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic [CHANNELS-1:0]       out_valid,
    input  logic [CHANNELS-1:0]       out_ready,
    output logic [CNT_W-1:0]          drop_cnt
);
    logic [CHANNELS-1:0]       free, load, valid_d, valid_q;
    logic [CHANNELS*WIDTH-1:0] data_d, data_q;
    logic [CNT_W-1:0]          cnt_d, cnt_q;
    logic                      in_range, accept, drop;

    // Handshake, per-channel load decode and next-state for slots and drop counter
    always_comb begin
        free = ~valid_q | out_ready;
        in_range = 32'(in_sel) < CHANNELS;
        in_ready = in_bcast ? &free : (in_range ? free[in_sel] : 1'b1);
        accept = in_valid & in_ready;
        drop = accept & ~in_bcast & ~in_range;
        load = '0;
        data_d = data_q;
        for (int k = 0; k < CHANNELS; k++) begin
            load[k] = accept & (in_bcast | (in_range & (32'(in_sel) == k)));
            data_d[k*WIDTH +: WIDTH] = load[k] ? in_data : data_q[k*WIDTH +: WIDTH];
        end
        valid_d = (valid_q & ~out_ready) | load;
        cnt_d = (drop & ~&cnt_q) ? cnt_q + 1'b1 : cnt_q;
    end

    // State registers; reset wins over any concurrent accept
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign drop_cnt  = cnt_q;
endmodule

// File: tb/tb_dmux_stream.sv
// tb_dmux_stream: directed self-checking bench for dmux_stream (4-channel and 3-channel instances)
module tb_dmux_stream;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  a_data;
    logic [1:0]  a_sel;
    logic        a_bcast, a_valid, a_ready;
    logic [31:0] a_odata;
    logic [3:0]  a_ovalid, a_oready;
    logic [7:0]  a_drop;
    logic [7:0]  b_data;
    logic [1:0]  b_sel;
    logic        b_bcast, b_valid, b_ready;
    logic [23:0] b_odata;
    logic [2:0]  b_ovalid, b_oready;
    logic [7:0]  b_drop;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmux_stream #(.WIDTH(8), .CHANNELS(4), .CNT_W(8)) u_a (
        .clk(clk), .rst(rst), .in_data(a_data), .in_sel(a_sel), .in_bcast(a_bcast),
        .in_valid(a_valid), .in_ready(a_ready), .out_data(a_odata), .out_valid(a_ovalid),
        .out_ready(a_oready), .drop_cnt(a_drop)
    );

    dmux_stream #(.WIDTH(8), .CHANNELS(3), .CNT_W(8)) u_b (
        .clk(clk), .rst(rst), .in_data(b_data), .in_sel(b_sel), .in_bcast(b_bcast),
        .in_valid(b_valid), .in_ready(b_ready), .out_data(b_odata), .out_valid(b_ovalid),
        .out_ready(b_oready), .drop_cnt(b_drop)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int bad_ready;
        int bad_valid;
        rst = 1'b1;
        a_data = 8'h77; a_sel = 2'd1; a_bcast = 1'b0; a_valid = 1'b1; a_oready = 4'hF;
        b_data = 8'h00; b_sel = 2'd0; b_bcast = 1'b0; b_valid = 1'b0; b_oready = 3'h7;
        tick();
        tick();
        rst = 1'b0; a_valid = 1'b0;
        #1;
        check("rst_valid", 32'(a_ovalid), 32'h0);
        check("rst_data", a_odata, 32'h0);
        check("rst_drop", 32'(a_drop), 32'h0);
        check("rst_ready", 32'(a_ready), 32'h1);

        for (int i = 0; i < 4; i++) begin
            a_valid = 1'b1; a_sel = 2'(i); a_data = 8'hA0 + 8'(i);
            #1;
            check("uni_ready", 32'(a_ready), 32'h1);
            tick();
            check("uni_valid", 32'(a_ovalid), 32'(4'b0001 << i));
            check("uni_data", 32'(a_odata[i*8 +: 8]), 32'hA0 + 32'(i));
        end
        a_valid = 1'b0;
        tick();
        check("uni_drained", 32'(a_ovalid), 32'h0);

        a_oready = 4'b1011;
        a_valid = 1'b1; a_sel = 2'd2; a_data = 8'hB1;
        tick();
        check("bp_first_valid", 32'(a_ovalid), 32'h4);
        check("bp_first_data", 32'(a_odata[23:16]), 32'hB1);
        a_sel = 2'd1; a_data = 8'hC1;
        #1;
        check("bp_ch1_ready", 32'(a_ready), 32'h1);
        tick();
        check("bp_ch1_valid", 32'(a_ovalid), 32'h6);
        check("bp_ch1_data", 32'(a_odata[15:8]), 32'hC1);
        a_sel = 2'd2; a_data = 8'hB2;
        #1;
        check("bp_stall_ready", 32'(a_ready), 32'h0);
        tick();
        check("bp_hold_valid", 32'(a_ovalid), 32'h4);
        check("bp_hold_data", 32'(a_odata[23:16]), 32'hB1);
        a_oready = 4'hF;
        #1;
        check("bp_release_ready", 32'(a_ready), 32'h1);
        tick();
        check("bp_swap_valid", 32'(a_ovalid), 32'h4);
        check("bp_swap_data", 32'(a_odata[23:16]), 32'hB2);
        a_valid = 1'b0;
        tick();
        check("bp_drained", 32'(a_ovalid), 32'h0);

        a_oready = 4'b0111;
        a_valid = 1'b1; a_sel = 2'd3; a_data = 8'hD3;
        tick();
        check("bc_fill3", 32'(a_ovalid), 32'h8);
        a_bcast = 1'b1; a_sel = 2'd0; a_data = 8'h5A;
        #1;
        check("bc_blocked_ready", 32'(a_ready), 32'h0);
        tick();
        check("bc_blocked_valid", 32'(a_ovalid), 32'h8);
        check("bc_blocked_data", a_odata, 32'hD3_B2_C1_A0);
        a_oready = 4'hF;
        #1;
        check("bc_release_ready", 32'(a_ready), 32'h1);
        tick();
        check("bc_all_valid", 32'(a_ovalid), 32'hF);
        check("bc_all_data", a_odata, 32'h5A5A5A5A);
        a_valid = 1'b0; a_bcast = 1'b0;
        tick();
        check("bc_drained", 32'(a_ovalid), 32'h0);

        bad_ready = 0;
        bad_valid = 0;
        for (int i = 0; i < 300; i++) begin
            b_valid = 1'b1; b_sel = 2'd3; b_data = 8'(i);
            #1;
            if (b_ready !== 1'b1) bad_ready++;
            tick();
            if (b_ovalid !== 3'b000) bad_valid++;
            if (i == 0) check("oor_drop_first", 32'(b_drop), 32'd1);
            if (i == 253) check("oor_drop_254", 32'(b_drop), 32'd254);
            if (i == 254) check("oor_drop_255", 32'(b_drop), 32'd255);
        end
        check("oor_ready_always", 32'(bad_ready), 32'd0);
        check("oor_no_valid", 32'(bad_valid), 32'd0);
        check("oor_drop_sat", 32'(b_drop), 32'd255);
        b_sel = 2'd2; b_data = 8'h3C;
        tick();
        check("b_inrange_valid", 32'(b_ovalid), 32'h4);
        check("b_inrange_data", 32'(b_odata), 32'h3C_0000);
        check("b_inrange_drop", 32'(b_drop), 32'd255);
        b_valid = 1'b0;

        a_oready = 4'b1100;
        a_valid = 1'b1; a_sel = 2'd0; a_data = 8'hE0;
        tick();
        a_sel = 2'd1; a_data = 8'hE1;
        tick();
        check("mid_full", 32'(a_ovalid), 32'h3);
        rst = 1'b1; a_sel = 2'd2; a_data = 8'hE2;
        tick();
        rst = 1'b0; a_valid = 1'b0;
        #1;
        check("mid_rst_valid", 32'(a_ovalid), 32'h0);
        check("mid_rst_data", a_odata, 32'h0);
        check("mid_rst_drop", 32'(a_drop), 32'h0);
        check("mid_rst_b_drop", 32'(b_drop), 32'h0);
        tick();
        check("mid_no_late_word", 32'(a_ovalid), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
